// File: rtl/mmio_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_controller
//  Description : CPU memory-mapped IO bridge. Decodes a small register window
//                (LEDs, switches, button interrupts) at the top of the 64K
//                space and passes every other access through to an external
//                SRAM with active-low control strobes. Buttons are
//                synchronized, debounced and latched as pending interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_controller #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 18,
    parameter int N_LED_R    = 10,
    parameter int N_LED_G    = 8,
    parameter int N_SW       = 10,
    parameter int N_BTN      = 4,
    parameter int DEBOUNCE   = 16,
    parameter int LED_TOGGLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [N_BTN-1:0]    buttons,
    input  logic [N_SW-1:0]     switches,
    output logic [N_LED_R-1:0]  led_r,
    output logic [N_LED_G-1:0]  led_g,
    output logic [4:0]          control_mem,
    output logic [N_BTN-1:0]    interruptions,
    inout  wire  [DATA_W-1:0]   data_cpu,
    inout  wire  [DATA_W-1:0]   data_mem
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (ADDR_W < 16) begin : g_chk_addr
        $error("mmio_controller: ADDR_W must be at least 16");
    end
    if (DEBOUNCE < 1) begin : g_chk_deb
        $error("mmio_controller: DEBOUNCE must be at least 1");
    end
    if (N_LED_R < 1 || N_LED_R > DATA_W || N_LED_G < 1 || N_LED_G > DATA_W ||
        N_SW < 1 || N_SW > DATA_W || N_BTN < 1 || N_BTN > DATA_W) begin : g_chk_widths
        $error("mmio_controller: register widths must lie in 1..DATA_W");
    end

    // Register indices within the IO window (addr[2:0])
    localparam logic [2:0] c_IDX_LED_G = 3'd7;
    localparam logic [2:0] c_IDX_LED_R = 3'd6;
    localparam logic [2:0] c_IDX_SW    = 3'd5;
    localparam logic [2:0] c_IDX_PEND  = 3'd4;
    localparam logic [2:0] c_IDX_MASK  = 3'd3;

    // Memory strobes {we, ce, oe, lb, ub}, active-low
    localparam logic [4:0] c_CTL_MEM_WR = 5'b00100;
    localparam logic [4:0] c_CTL_MEM_RD = 5'b10000;
    localparam logic [4:0] c_CTL_IDLE   = 5'b11111;

    localparam int               CNT_W      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(DEBOUNCE - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       w_io_sel;
    logic [2:0] w_reg_idx;
    logic       w_wr_led_g;
    logic       w_wr_led_r;
    logic       w_wr_pend;
    logic       w_wr_mask;

    assign w_io_sel   = &addr[15:3];
    assign w_reg_idx  = addr[2:0];
    assign w_wr_led_g = wr && w_io_sel && (w_reg_idx == c_IDX_LED_G);
    assign w_wr_led_r = wr && w_io_sel && (w_reg_idx == c_IDX_LED_R);
    assign w_wr_pend  = wr && w_io_sel && (w_reg_idx == c_IDX_PEND);
    assign w_wr_mask  = wr && w_io_sel && (w_reg_idx == c_IDX_MASK);

    // Upper address bits and wide data bits are intentionally not decoded
    logic w_unused;
    assign w_unused = ^{addr, data_cpu};

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [N_LED_R-1:0] led_r_q, led_r_d;
    logic [N_LED_G-1:0] led_g_q, led_g_d;
    logic [N_BTN-1:0]   pend_q,  pend_d;
    logic [N_BTN-1:0]   mask_q,  mask_d;
    logic [N_SW-1:0]    sw_meta_q, sw_sync_q;
    logic [N_BTN-1:0]   btn_meta_q, btn_sync_q;
    logic [N_BTN-1:0]   w_deb;
    logic [N_BTN-1:0]   w_rise;

    // Next-state for the CPU-writable registers and the pending latch
    always_comb begin
        led_r_d = led_r_q;
        led_g_d = led_g_q;
        mask_d  = mask_q;
        if (w_wr_led_r) begin
            led_r_d = (LED_TOGGLE != 0) ? (led_r_q ^ data_cpu[N_LED_R-1:0])
                                        : data_cpu[N_LED_R-1:0];
        end
        if (w_wr_led_g) begin
            led_g_d = (LED_TOGGLE != 0) ? (led_g_q ^ data_cpu[N_LED_G-1:0])
                                        : data_cpu[N_LED_G-1:0];
        end
        if (w_wr_mask) begin
            mask_d = data_cpu[N_BTN-1:0];
        end
        // Clear first, then OR in new rises so a simultaneous set wins
        pend_d = pend_q;
        if (w_wr_pend) begin
            pend_d = pend_q & ~data_cpu[N_BTN-1:0];
        end
        pend_d = pend_d | w_rise;
    end

    // Register file update; mask resets to all ones so IRQs are live by default
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r_q <= '0;
            led_g_q <= '0;
            pend_q  <= '0;
            mask_q  <= '1;
        end else begin
            led_r_q <= led_r_d;
            led_g_q <= led_g_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
        end
    end

    // Two-flop synchronizers for switches and buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            sw_meta_q  <= switches;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= buttons;
            btn_sync_q <= btn_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce: accept a new level after DEBOUNCE consecutive
    // mismatching synchronized samples; report the 0->1 acceptance as a rise.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             deb_q, deb_d;
        logic             rise_w;

        // Count mismatches and flip the accepted level on the last one
        always_comb begin
            cnt_d  = cnt_q;
            deb_d  = deb_q;
            rise_w = 1'b0;
            if (btn_sync_q[gi] == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == c_CNT_MAX) begin
                deb_d  = btn_sync_q[gi];
                cnt_d  = '0;
                rise_w = btn_sync_q[gi];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Debounce state; reset discards any partial count
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                deb_q <= deb_d;
            end
        end

        assign w_rise[gi] = rise_w;
        assign w_deb[gi]  = deb_q;
    end

    // ------------------------------------------------------------------
    // Read mux and bus steering
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rd_data;

    // Zero-extended read of the selected IO register; reserved slots read 0
    always_comb begin
        w_rd_data = '0;
        case (w_reg_idx)
            c_IDX_LED_G: w_rd_data[N_LED_G-1:0] = led_g_q;
            c_IDX_LED_R: w_rd_data[N_LED_R-1:0] = led_r_q;
            c_IDX_SW:    w_rd_data[N_SW-1:0]    = sw_sync_q;
            c_IDX_PEND:  w_rd_data[N_BTN-1:0]   = pend_q;
            c_IDX_MASK:  w_rd_data[N_BTN-1:0]   = mask_q;
            default:     w_rd_data              = '0;
        endcase
    end

    // Memory strobes depend only on decode and direction, valid in reset too
    always_comb begin
        control_mem = c_CTL_IDLE;
        if (!w_io_sel) begin
            control_mem = wr ? c_CTL_MEM_WR : c_CTL_MEM_RD;
        end
    end

    // Each bus is driven only in its own direction, never both at once
    assign data_cpu = !wr ? (w_io_sel ? w_rd_data : data_mem) : {DATA_W{1'bz}};
    assign data_mem = (wr && !w_io_sel) ? data_cpu : {DATA_W{1'bz}};

    assign led_r         = led_r_q;
    assign led_g         = led_g_q;
    assign interruptions = pend_q & mask_q;

    // Accepted button levels are kept for observability of the debouncer
    logic w_unused_deb;
    assign w_unused_deb = ^w_deb;

endmodule
`default_nettype wire

// File: tb/tb_mmio_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_controller
//  Description : Directed self-checking bench for mmio_controller
//                (DEBOUNCE=4, other parameters default).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_controller;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 18;

    logic              clk;
    logic              reset;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        buttons;
    logic [9:0]        switches;
    logic [9:0]        led_r;
    logic [7:0]        led_g;
    logic [4:0]        control_mem;
    logic [3:0]        interruptions;
    wire  [DATA_W-1:0] data_cpu;
    wire  [DATA_W-1:0] data_mem;

    logic              cpu_en;
    logic [DATA_W-1:0] cpu_val;
    logic              mem_en;
    logic [DATA_W-1:0] mem_val;

    int vectors;
    int miscompares;

    assign data_cpu = cpu_en ? cpu_val : {DATA_W{1'bz}};
    assign data_mem = mem_en ? mem_val : {DATA_W{1'bz}};

    mmio_controller #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .N_LED_R    (10),
        .N_LED_G    (8),
        .N_SW       (10),
        .N_BTN      (4),
        .DEBOUNCE   (4),
        .LED_TOGGLE (1)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .wr            (wr),
        .addr          (addr),
        .buttons       (buttons),
        .switches      (switches),
        .led_r         (led_r),
        .led_g         (led_g),
        .control_mem   (control_mem),
        .interruptions (interruptions),
        .data_cpu      (data_cpu),
        .data_mem      (data_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CPU IO/memory write held across one edge, then bus released
    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr      = 1'b1;
        addr    = a;
        cpu_en  = 1'b1;
        cpu_val = d;
        tick(1);
        wr      = 1'b0;
        cpu_en  = 1'b0;
    endtask

    task automatic cpu_read_check(input string tag, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] exp);
        wr     = 1'b0;
        cpu_en = 1'b0;
        addr   = a;
        #1;
        check(tag, 32'(data_cpu), 32'(exp));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        wr          = 1'b0;
        addr        = 18'h01234;
        buttons     = 4'b0000;
        switches    = 10'h000;
        cpu_en      = 1'b0;
        cpu_val     = '0;
        mem_en      = 1'b0;
        mem_val     = '0;

        // Reset state and combinational strobes during reset
        tick(2);
        check("rst_led_r", 32'(led_r), 32'h000);
        check("rst_led_g", 32'(led_g), 32'h00);
        check("rst_irq", 32'(interruptions), 32'h0);
        check("rst_ctl_memrd", 32'(control_mem), 32'b10000);
        cpu_read_check("rst_mask", 18'h0FFFB, 16'h000F);
        reset = 1'b0;
        tick(1);

        // LED_R toggle-write twice
        cpu_write(18'h0FFFE, 16'h03FF);
        check("led_r_w1", 32'(led_r), 32'h3FF);
        cpu_write(18'h0FFFE, 16'h03FF);
        check("led_r_w2", 32'(led_r), 32'h000);

        // LED_G toggle with excess bits ignored, readback
        cpu_write(18'h0FFFF, 16'hFFA5);
        check("led_g_w", 32'(led_g), 32'hA5);
        cpu_read_check("led_g_rd", 18'h0FFFF, 16'h00A5);
        cpu_write(18'h0FFFF, 16'h000F);
        check("led_g_tog", 32'(led_g), 32'hAA);

        // Button 0 held: pending after edge k+5, not after k+4
        buttons = 4'b0001;
        tick(5);
        check("btn0_k4", 32'(interruptions), 32'h0);
        tick(1);
        check("btn0_k5", 32'(interruptions), 32'h1);
        buttons = 4'b0000;
        tick(10);
        check("btn0_release", 32'(interruptions), 32'h1);
        cpu_read_check("btn0_pend_rd", 18'h0FFFC, 16'h0001);
        cpu_write(18'h0FFFC, 16'h0001);
        check("btn0_w1c", 32'(interruptions), 32'h0);

        // 3-cycle glitch on button 2 is rejected
        buttons = 4'b0100;
        tick(3);
        buttons = 4'b0000;
        tick(10);
        check("glitch_irq", 32'(interruptions), 32'h0);
        cpu_read_check("glitch_pend", 18'h0FFFC, 16'h0000);

        // Masked press still latches pending
        cpu_write(18'h0FFFB, 16'h0000);
        buttons = 4'b0010;
        tick(10);
        buttons = 4'b0000;
        tick(10);
        check("mask_irq", 32'(interruptions), 32'h0);
        cpu_read_check("mask_pend", 18'h0FFFC, 16'h0002);
        cpu_write(18'h0FFFB, 16'h000F);
        check("unmask_irq", 32'(interruptions), 32'h2);
        cpu_write(18'h0FFFC, 16'h0002);
        check("unmask_w1c", 32'(interruptions), 32'h0);

        // Memory write pass-through
        wr      = 1'b1;
        addr    = 18'h01234;
        cpu_en  = 1'b1;
        cpu_val = 16'hBEEF;
        #1;
        check("memwr_ctl", 32'(control_mem), 32'b00100);
        check("memwr_data", 32'(data_mem), 32'hBEEF);
        wr     = 1'b0;
        cpu_en = 1'b0;

        // Memory read pass-through
        mem_en  = 1'b1;
        mem_val = 16'h1234;
        addr    = 18'h00010;
        #1;
        check("memrd_ctl", 32'(control_mem), 32'b10000);
        check("memrd_data", 32'(data_cpu), 32'h1234);
        mem_en = 1'b0;

        // Switch read through 2-flop sync; upper address bits ignored
        tick(1);
        switches = 10'h155;
        addr     = 18'h3FFFD;
        tick(1);
        cpu_read_check("sw_1edge", 18'h3FFFD, 16'h0000);
        tick(1);
        cpu_read_check("sw_2edge", 18'h3FFFD, 16'h0155);
        check("sw_ctl", 32'(control_mem), 32'b11111);

        // Reserved slots read 0 and ignore writes
        cpu_write(18'h0FFF8, 16'hFFFF);
        cpu_read_check("resv_rd", 18'h0FFF8, 16'h0000);
        check("resv_led_r", 32'(led_r), 32'h000);

        // W1C on the same edge as deb[3] rising: set wins
        buttons = 4'b1000;
        tick(5);
        check("w1c_race_pre", 32'(interruptions), 32'h0);
        cpu_write(18'h0FFFC, 16'h0008);
        check("w1c_race_set", 32'(interruptions), 32'h8);
        buttons = 4'b0000;
        tick(10);
        cpu_write(18'h0FFFC, 16'h0008);
        check("w1c_race_clr", 32'(interruptions), 32'h0);

        // Reset mid-debounce: progress discarded, count restarts after release
        buttons = 4'b0001;
        tick(4);
        reset = 1'b1;
        #1;
        check("async_rst_led_g", 32'(led_g), 32'h00);
        tick(1);
        reset = 1'b0;
        tick(5);
        check("rst_mid_k4", 32'(interruptions), 32'h0);
        tick(1);
        check("rst_mid_k5", 32'(interruptions), 32'h1);
        tick(20);
        cpu_write(18'h0FFFC, 16'h0001);
        tick(10);
        check("held_once", 32'(interruptions), 32'h0);
        buttons = 4'b0000;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
